// File: rtl/conv_out_requant.sv
`default_nettype none
// ============================================================================
// Module      : conv_out_requant
// Description : Captures one complete convolution result frame
//               (output_size*output_size signed elements) when in_valid
//               rises. It then streams the elements out one per accepted
//               handshake. Each element is arithmetically shifted right by
//               `shift` (floor) and then saturated to the signed
//               word_length range.
//               Optional feature macro: RELU_EN. When it is defined,
//               negative elements are clamped to zero before the shift.
// Ports       : clk       - clock, all flops rising-edge
//               rst       - asynchronous active-high reset
//               in_valid  - frame valid from the conv stage; a rising edge
//                           starts a frame
//               data_in   - whole frame; element w is at
//                           [double_word_length*w +: double_word_length]
//               data_out  - requantised pixel (two's complement)
//               out_valid - data_out holds a valid pixel
//               out_ready - downstream accepts the pixel when high
//               busy      - a frame is held and not fully emitted
//               drop_err  - one-cycle pulse when an incoming frame is
//                           discarded
// Revision    : 1.0 - initial release
// ============================================================================
module conv_out_requant #(
    parameter int word_length        = 8,
    parameter int double_word_length = 16,
    parameter int output_size        = 32,
    parameter int shift              = 4
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                in_valid,
    input  logic [double_word_length*output_size*output_size-1:0] data_in,
    output logic [word_length-1:0]                              data_out,
    output logic                                                out_valid,
    input  logic                                                out_ready,
    output logic                                                busy,
    output logic                                                drop_err
);

    localparam int c_frame = output_size * output_size;
    localparam int c_idx_w = (c_frame > 1) ? $clog2(c_frame) : 1;
    localparam logic [c_idx_w-1:0] c_last = c_idx_w'(c_frame - 1);
    localparam logic [c_idx_w-1:0] c_one  = c_idx_w'(1);
    localparam logic signed [double_word_length-1:0] c_max =
        double_word_length'((1 << (word_length - 1)) - 1);
    localparam logic signed [double_word_length-1:0] c_min =
        double_word_length'(-(1 << (word_length - 1)));

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                                r_state;
    logic [double_word_length*c_frame-1:0] r_frame;
    logic [c_idx_w-1:0]                    r_idx;
    logic                                  r_in_valid_q;
    logic                                  r_armed;
    logic                                  r_out_valid;
    logic                                  r_drop_err;
    logic [word_length-1:0]                r_data_out;

    logic                                  w_frame_start;
    logic                                  w_accept;
    logic                                  w_last_accept;
    logic                                  w_capture;
    logic [c_idx_w-1:0]                    w_next_idx;
    logic [double_word_length-1:0]         w_next_elem;
    logic [double_word_length-1:0]         w_new_elem0;

    // Optional ReLU, then floor shift, then saturation to the pixel range.
    function automatic logic [word_length-1:0] requant(
        input logic [double_word_length-1:0] x
    );
        logic signed [double_word_length-1:0] v;
        logic signed [double_word_length-1:0] s;
        v = x;
`ifdef RELU_EN
        if (v[double_word_length-1]) begin
            v = '0;
        end
`endif
        s = v >>> shift;
        if (s > c_max) begin
            requant = c_max[word_length-1:0];
        end else if (s < c_min) begin
            requant = c_min[word_length-1:0];
        end else begin
            requant = s[word_length-1:0];
        end
    endfunction

    // r_armed stays low after reset until in_valid has been sampled low.
    // A level held across reset release therefore cannot look like an edge.
    assign w_frame_start = in_valid & ~r_in_valid_q & r_armed;
    assign w_accept      = r_out_valid & out_ready;
    assign w_last_accept = (r_state == STREAM) & w_accept & (r_idx == c_last);
    assign w_capture     = ((r_state == IDLE) & w_frame_start) |
                           (w_last_accept & w_frame_start);
    assign w_next_idx    = r_idx + c_one;
    assign w_next_elem   = r_frame[double_word_length*w_next_idx +: double_word_length];
    assign w_new_elem0   = data_in[double_word_length-1:0];

    // Frame storage needs no reset: the state machine alone decides
    // whether its contents are live.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_frame <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_in_valid_q <= 1'b0;
            r_armed      <= 1'b0;
            r_out_valid  <= 1'b0;
            r_drop_err   <= 1'b0;
            r_data_out   <= '0;
        end else begin
            r_in_valid_q <= in_valid;
            r_drop_err   <= 1'b0;
            if (!in_valid) begin
                r_armed <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_frame_start) begin
                        r_state     <= STREAM;
                        r_idx       <= '0;
                        r_out_valid <= 1'b1;
                        r_data_out  <= requant(w_new_elem0);
                    end
                end
                STREAM: begin
                    if (w_accept) begin
                        if (r_idx == c_last) begin
                            if (w_frame_start) begin
                                // Back-to-back frame: no bubble on out_valid.
                                r_idx      <= '0;
                                r_data_out <= requant(w_new_elem0);
                            end else begin
                                r_state     <= IDLE;
                                r_out_valid <= 1'b0;
                            end
                        end else begin
                            r_idx      <= w_next_idx;
                            r_data_out <= requant(w_next_elem);
                        end
                    end
                    if (w_frame_start && !w_last_accept) begin
                        r_drop_err <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign data_out  = r_data_out;
    assign out_valid = r_out_valid;
    assign busy      = (r_state == STREAM);
    assign drop_err  = r_drop_err;

endmodule
`default_nettype wire

// File: tb/tb_conv_out_requant.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_out_requant
// Description : Scoreboard bench for conv_out_requant (output_size=32,
//               shift=4). Expected pixels are queued when a frame is
//               issued. A monitor pops and compares them on every
//               accepted pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_out_requant;

    localparam int c_n  = 1024;
    localparam int c_fw = 16 * c_n;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [c_fw-1:0] data_in;
    logic [7:0]      data_out;
    logic            out_valid;
    logic            out_ready;
    logic            busy;
    logic            drop_err;

    int         tests = 0;
    int         fails = 0;
    int         drop_cnt = 0;
    int         gap_cnt = 0;
    bit         watch_gap = 1'b0;
    bit         stalled = 1'b0;
    logic [7:0] held;
    logic [7:0] exp_q[$];

    conv_out_requant #(
        .word_length(8), .double_word_length(16), .output_size(32), .shift(4)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
        .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    // Reference requant: floor division by 16, then clamp to [-128, 127].
    function automatic logic [7:0] model(input logic [15:0] e);
        int v;
        int q;
        v = int'($signed(e));
`ifdef RELU_EN
        if (v < 0) v = 0;
`endif
        q = (v >= 0) ? (v / 16) : -((-v + 15) / 16);
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        return q[7:0];
    endfunction

    function automatic logic [c_fw-1:0] make_frame(input int seed);
        logic [c_fw-1:0] f;
        for (int w = 0; w < c_n; w++) begin
            f[16*w +: 16] = 16'(w * 1237 + seed * 7919);
        end
        return f;
    endfunction

    task automatic push_frame(input logic [c_fw-1:0] f);
        for (int w = 0; w < c_n; w++) exp_q.push_back(model(f[16*w +: 16]));
    endtask

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Wait for busy to drop. The bound expiring counts as a failure.
    task automatic wait_idle(input int max, input bit toggle, input string name,
                             output int cycles);
        cycles = 0;
        while (1) begin
            @(posedge clk); #1;
            cycles++;
            if (!busy) break;
            if (cycles >= max) begin
                tests++;
                fails++;
                $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", name, cycles);
                break;
            end
            if (toggle) out_ready = ~out_ready;
        end
    endtask

    // Monitor: the scoreboard check on every accepted pixel, plus a
    // stability check on stalls.
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (out_valid) begin
                if (stalled) begin
                    tests++;
                    if (data_out !== held) begin
                        fails++;
                        $display("FAIL stall_stable: got %h, expected %h", data_out, held);
                    end
                end
                if (out_ready) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_pixel: got %h, expected no output", data_out);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        if (data_out !== e) begin
                            fails++;
                            $display("FAIL pixel: got %h, expected %h (%0d left)", data_out, e, exp_q.size());
                        end
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = data_out;
                end
            end else begin
                stalled = 1'b0;
            end
            if (drop_err) drop_cnt++;
            if (watch_gap && !out_valid) gap_cnt++;
        end
    end

    initial begin
        logic [c_fw-1:0] fa;
        logic [c_fw-1:0] fb;
        logic [7:0]      d0;
        logic [7:0]      d1;
        logic [7:0]      d2;
        logic [7:0]      d3;
        logic [7:0]      d4;
        int              cyc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_drop_err", int'(drop_err), 0);
        check("rst_data_out", int'(data_out), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Frame A: directed values in elements 0..4. in_valid is held high
        // as a level for a few cycles, which must not cause a drop.
        fa = make_frame(1);
        fa[15:0]  = 16'h0070; fa[31:16] = 16'h7FFF; fa[47:32] = 16'hFF00;
        fa[63:48] = 16'h8000; fa[79:64] = 16'hFFFF;
`ifdef RELU_EN
        d0 = 8'h07; d1 = 8'h7F; d2 = 8'h00; d3 = 8'h00; d4 = 8'h00;
`else
        d0 = 8'h07; d1 = 8'h7F; d2 = 8'hF0; d3 = 8'h80; d4 = 8'hFF;
`endif
        exp_q.push_back(d0); exp_q.push_back(d1); exp_q.push_back(d2);
        exp_q.push_back(d3); exp_q.push_back(d4);
        for (int w = 5; w < c_n; w++) exp_q.push_back(model(fa[16*w +: 16]));
        drop_cnt = 0;
        out_ready = 1'b1;
        data_in = fa; in_valid = 1'b1;
        @(negedge clk);
        check("pre_capture_out_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        check("first_out_valid", int'(out_valid), 1);
        check("first_busy", int'(busy), 1);
        repeat (4) @(posedge clk);
        #1 in_valid = 1'b0;
        wait_idle(1100, 1'b0, "frameA", cyc);
        check("frameA_level_no_drop", drop_cnt, 0);
        check("frameA_all_emitted", exp_q.size(), 0);
        check("frameA_out_valid_low", int'(out_valid), 0);

        // Frame B: out_ready alternates every cycle.
        fb = make_frame(2);
        push_frame(fb);
        data_in = fb; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        wait_idle(2200, 1'b1, "frameB", cyc);
        tests++;
        if (cyc < 2040 || cyc > 2056) begin
            fails++;
            $display("FAIL toggle_duration: got %0d cycles, expected about 2047", cyc);
        end
        check("frameB_all_emitted", exp_q.size(), 0);
        check("frameB_busy_low", int'(busy), 0);
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Frame C: a second rising edge near element 500 is dropped.
        fa = make_frame(3);
        push_frame(fa);
        drop_cnt = 0;
        data_in = fa; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (499) @(posedge clk);
        #1;
        data_in = make_frame(9); in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        wait_idle(1100, 1'b0, "frameC", cyc);
        check("drop_err_one_cycle", drop_cnt, 1);
        check("frameC_all_emitted", exp_q.size(), 0);

        // Frames D1/D2: a new frame start coincides with acceptance of
        // element 1023.
        fa = make_frame(4);
        fb = make_frame(5);
        push_frame(fa);
        drop_cnt = 0; gap_cnt = 0;
        data_in = fa; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        watch_gap = 1'b1;
        repeat (1023) @(posedge clk);
        #1;
        push_frame(fb);
        data_in = fb; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        check("b2b_out_valid", int'(out_valid), 1);
        check("b2b_busy", int'(busy), 1);
        repeat (5) @(posedge clk);
        #1 watch_gap = 1'b0;
        check("b2b_no_bubble", gap_cnt, 0);
        wait_idle(1100, 1'b0, "frameD2", cyc);
        check("b2b_no_drop", drop_cnt, 0);
        check("b2b_all_emitted", exp_q.size(), 0);

        // Frame E: reset near element 300. in_valid is held high across
        // the release, which must not restart a frame.
        fa = make_frame(6);
        push_frame(fa);
        data_in = fa; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (300) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_busy", int'(busy), 0);
        exp_q.delete();
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("post_rst_level_busy", int'(busy), 0);
        check("post_rst_level_out_valid", int'(out_valid), 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("post_rst_idle_busy", int'(busy), 0);

        // Frame F: streaming works normally after the reset.
        fb = make_frame(7);
        push_frame(fb);
        data_in = fb; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        check("post_rst_restart_valid", int'(out_valid), 1);
        wait_idle(1100, 1'b0, "frameF", cyc);
        check("frameF_all_emitted", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_out_requant.md
CONV_OUT_REQUANT -- requirements
Module: conv_out_requant

Interface
REQ-001 SHALL have parameter: word_length, 8, output pixel width.
REQ-002 SHALL have parameter: double_word_length, 16, conv result element width.
REQ-003 SHALL have parameter: output_size, 32, conv output frame edge; frame = output_size*output_size elements.
REQ-004 SHALL have parameter: shift, 4, requantisation right-shift amount (0..15).
REQ-005 SHALL have port: clk  input  1  single clock, all flops rising-edge.
REQ-006 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port: in_valid  input  1  conv frame-valid from upstream conv stage.
REQ-008 SHALL have port: data_in  input  double_word_length*output_size*output_size  signed frame; element w at bits [double_word_length*w +: double_word_length].
REQ-009 SHALL have port: data_out  output  word_length  requantised pixel, two's complement.
REQ-010 SHALL have port: out_valid  output  1  data_out holds a valid pixel.
REQ-011 SHALL have port: out_ready  input  1  downstream accepts pixel when high with out_valid.
REQ-012 SHALL have port: busy  output  1  frame held and not fully emitted.
REQ-013 SHALL have port: drop_err  output  1  one-cycle pulse, incoming frame discarded.

Function
REQ-014 SHALL keep state machine IDLE/STREAM plus frame register, element index, and registered in_valid for edge detection.
REQ-015 SHALL detect a frame start as in_valid high in the current cycle and low in the previous registered cycle; a level held high SHALL NOT recapture.
REQ-016 In IDLE on a frame start, SHALL capture all of data_in, set index 0, enter STREAM; out_valid SHALL rise the next cycle with element 0.
REQ-017 In STREAM, index SHALL advance by one only on a cycle with out_valid and out_ready both high; emission order element 0 to element frame-1.
REQ-018 While out_valid high and out_ready low, data_out SHALL be held stable.
REQ-019 On acceptance of element frame-1 with no coincident frame start, SHALL return to IDLE and deassert out_valid next cycle.
REQ-020 On acceptance of element frame-1 coincident with a frame start, SHALL capture the new frame, stay in STREAM, and present its element 0 next cycle with no bubble.
REQ-021 A frame start in STREAM other than per REQ-020 SHALL be ignored and drop_err SHALL pulse high for exactly one cycle; the held frame SHALL be unaffected.
REQ-022 Requant per element: arithmetic shift right by shift (floor), then saturate to [-128, 127]; data_out registered.
REQ-023 busy SHALL equal (state == STREAM).
REQ-024 Throughput SHALL be one pixel per cycle with out_ready held high; frame emission = output_size*output_size cycles.

Reset
REQ-025 rst high SHALL asynchronously force state IDLE, index 0, registered in_valid 0, data_out 0, out_valid 0, busy 0, drop_err 0.
REQ-026 rst asserted mid-frame SHALL discard the held frame; after release, no output SHALL occur until a new frame start.
REQ-027 in_valid held high across rst release SHALL NOT count as a frame start (registered in_valid resets to 0 but edge requires a prior low sample after release).

Configuration
REQ-028 Macro RELU_EN: when defined, elements with negative value SHALL become 0 before shift/saturation, so data_out is in [0, 127].
REQ-029 Without RELU_EN, negative values SHALL pass through shift and saturation unchanged in sign.

Verification (output_size=32, shift=4)
REQ-030 Frame el0=16'h0070, el1=16'h7FFF, out_ready=1 -> out_valid one cycle after capture, data_out 8'h07 then 8'h7F.
REQ-031 el2=16'hFF00, el3=16'h8000, el4=16'hFFFF -> 8'hF0, 8'h80, 8'hFF without RELU_EN; 8'h00, 8'h00, 8'h00 with RELU_EN.
REQ-032 out_ready toggled 1/0 each cycle -> 1024 pixels emitted in order over 2048 cycles, data_out stable in stall cycles, busy low after last.
REQ-033 Second in_valid rising edge at element 500 -> drop_err high one cycle, remaining elements from first frame unchanged.
REQ-034 Frame start coincident with acceptance of element 1023 -> next-cycle data_out is new frame element 0, out_valid never drops.
REQ-035 rst pulsed at element 300 -> out_valid/busy low immediately; no output until next frame start.
